// File: rtl/frame_dump_ctrl.sv
// Frame dump controller: freezes the camera write path after a triggered frame,
// then streams every pixel byte out through a ready/start serial handshake.
// Optional 4-byte sync header before pixel 0 when FRAME_DUMP_HEADER_EN is defined.
module frame_dump_ctrl #(
    parameter int          NUM_PIXELS = 307200,
    parameter logic [7:0]  HDR_BYTE   = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trigger,
    input  logic        frame_done,
    input  logic        cam_we_i,
    output logic        cam_we_o,
    output logic [16:0] ram_addr,
    input  logic [31:0] ram_data,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_ready,
    output logic        busy,
    output logic [18:0] pix_idx
);

    // Transmitter handshake: a byte is offered while tx_ready=1 in SEND with a
    // one-cycle tx_start; it is complete only after tx_ready goes 1->0->1.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
`ifdef FRAME_DUMP_HEADER_EN
        HDR       = 3'd2,
`endif
        READ      = 3'd3,
        LATCH     = 3'd4,
        SEND      = 3'd5,
        WAIT_ACK  = 3'd6,
        WAIT_DONE = 3'd7
    } state_t;

    localparam logic [18:0] LAST_PIX = 19'(NUM_PIXELS - 1);

    state_t      state;
    state_t      state_d;
    logic        trig_q;
    logic        freeze;
    logic        last_pix;
    logic [4:0]  byte_lsb;
`ifdef FRAME_DUMP_HEADER_EN
    logic [1:0]  hdr_cnt;
    logic        hdr_phase;
`endif

    assign last_pix = (pix_idx == LAST_PIX);
    assign byte_lsb = {pix_idx[1:0], 3'b000};
    assign cam_we_o = cam_we_i & ~freeze;
    assign busy     = (state != IDLE);
    // Driven straight from pix_idx so the word is on the RAM bus during READ
    // and its data is ready to be latched in LATCH.
    assign ram_addr = pix_idx[18:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:      if (trigger && !trig_q) state_d = ARM;
            ARM: begin
                if (frame_done) begin
`ifdef FRAME_DUMP_HEADER_EN
                    state_d = HDR;
`else
                    state_d = READ;
`endif
                end
            end
`ifdef FRAME_DUMP_HEADER_EN
            HDR:       state_d = SEND;
`endif
            READ:      state_d = LATCH;
            LATCH:     state_d = SEND;
            SEND:      if (tx_ready) state_d = WAIT_ACK;
            WAIT_ACK:  if (!tx_ready) state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (tx_ready) begin
`ifdef FRAME_DUMP_HEADER_EN
                    if (hdr_phase) state_d = (hdr_cnt == 2'd3) ? READ : HDR;
                    else
`endif
                    if (last_pix) state_d = IDLE;
                    else          state_d = READ;
                end
            end
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trig_q    <= 1'b0;
            freeze    <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= 8'd0;
            pix_idx   <= 19'd0;
`ifdef FRAME_DUMP_HEADER_EN
            hdr_cnt   <= 2'd0;
            hdr_phase <= 1'b0;
`endif
        end else begin
            trig_q   <= trigger;
            tx_start <= (state == SEND) && tx_ready;
            case (state)
                ARM: begin
                    if (frame_done) begin
                        freeze  <= 1'b1;
                        pix_idx <= 19'd0;
`ifdef FRAME_DUMP_HEADER_EN
                        hdr_cnt   <= 2'd0;
                        hdr_phase <= 1'b1;
`endif
                    end
                end
`ifdef FRAME_DUMP_HEADER_EN
                HDR:   tx_data <= hdr_cnt[0] ? ~HDR_BYTE : HDR_BYTE;
`endif
                LATCH: tx_data <= ram_data[byte_lsb +: 8];
                WAIT_DONE: begin
                    if (tx_ready) begin
`ifdef FRAME_DUMP_HEADER_EN
                        if (hdr_phase) begin
                            hdr_cnt <= hdr_cnt + 2'd1;
                            if (hdr_cnt == 2'd3) hdr_phase <= 1'b0;
                        end else
`endif
                        if (last_pix) begin
                            pix_idx <= 19'd0;
                            freeze  <= 1'b0;
                        end else begin
                            pix_idx <= pix_idx + 19'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/frame_dump_ctrl.md
FRAME_DUMP_CTRL -- requirements
Module: frame_dump_ctrl

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 307200: pixels per frame, a multiple of 4 and at most 2^19.
REQ-002 SHALL have parameter HDR_BYTE, default 8'hA5: sync byte value, used only when FRAME_DUMP_HEADER_EN is defined.
REQ-003 SHALL have port: clk  in  1  single clock for all logic.
REQ-004 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port: trigger  in  1  level; a 0->1 edge requests one frame dump.
REQ-006 SHALL have port: frame_done  in  1  one-cycle pulse from the receiver at the end of a frame.
REQ-007 SHALL have port: cam_we_i  in  1  receiver write enable.
REQ-008 SHALL have port: cam_we_o  out  1  gated write enable to frame RAM port A.
REQ-009 SHALL have port: ram_addr  out  17  word address to frame RAM port B.
REQ-010 SHALL have port: ram_data  in  32  port B read data, valid 1 cycle after ram_addr.
REQ-011 SHALL have port: tx_data  out  8  byte to the serial transmitter.
REQ-012 SHALL have port: tx_start  out  1  one-cycle send strobe.
REQ-013 SHALL have port: tx_ready  in  1  transmitter idle.
REQ-014 SHALL have port: busy  out  1  high in any state other than IDLE.
REQ-015 SHALL have port: pix_idx  out  19  index of the current pixel.

Function
REQ-016 SHALL implement FSM states IDLE, ARM, HDR, READ, LATCH, SEND, WAIT_ACK, WAIT_DONE.
REQ-017 IDLE: SHALL move to ARM on a trigger rising edge, detected with a registered copy of trigger; other trigger activity is ignored while busy.
REQ-018 ARM: on frame_done=1, SHALL set freeze=1 and move to HDR if the header is compiled in, else to READ; pix_idx=0.
REQ-019 cam_we_o SHALL equal cam_we_i & ~freeze (combinational).
REQ-020 READ: ram_addr SHALL be set to pix_idx[18:2]; SHALL then move to LATCH.
REQ-021 LATCH: SHALL register tx_data = ram_data[8*b+7:8*b], where b = pix_idx[1:0]; SHALL then move to SEND.
REQ-022 SEND: SHALL wait while tx_ready=0; when tx_ready=1, SHALL assert tx_start for exactly 1 cycle and move to WAIT_ACK.
REQ-023 WAIT_ACK: SHALL stay until tx_ready=0, then move to WAIT_DONE.
REQ-024 WAIT_DONE: SHALL stay until tx_ready=1.
REQ-025 On leaving WAIT_DONE with pix_idx = NUM_PIXELS-1: SHALL set pix_idx=0, clear freeze and go to IDLE.
REQ-026 On leaving WAIT_DONE otherwise: SHALL increment pix_idx and go to READ.
REQ-027 Every pixel byte SHALL be re-read from RAM; the block SHALL NOT cache whole words.
REQ-028 Minimum per-byte overhead with an always-ready transmitter SHALL be 5 cycles: READ, LATCH, SEND, WAIT_ACK, WAIT_DONE.
REQ-029 A frame_done pulse outside ARM SHALL have no effect.
REQ-030 tx_ready=1 on the first WAIT_ACK cycle SHALL NOT end the handshake; only the 1->0->1 sequence completes a byte.

Reset
REQ-031 Synchronous reset SHALL set: state=IDLE, freeze=0, tx_start=0, tx_data=0, ram_addr=0, pix_idx=0, busy=0, header counter=0, trigger edge register=0.
REQ-032 Reset asserted mid-dump SHALL abort immediately: the current byte is not completed and cam_we_o follows cam_we_i on the next cycle.

Configuration
REQ-033 Macro FRAME_DUMP_HEADER_EN, when defined: state HDR SHALL send 4 bytes before pixel 0, each using the SEND/WAIT_ACK/WAIT_DONE handshake; the bytes are HDR_BYTE, ~HDR_BYTE, HDR_BYTE, ~HDR_BYTE; HDR SHALL then move to READ.
REQ-034 Macro FRAME_DUMP_HEADER_EN, when undefined: state HDR and its 2-bit counter SHALL be absent, and the first tx byte is pixel 0.

Verification (NUM_PIXELS=8, RAM word0=32'h44332211, word1=32'h88776655, transmitter model: ready drops 1 cycle after start, rises 3 cycles later)
REQ-035 trigger 0->1, frame_done pulse 10 cycles later -> tx bytes 11,22,33,44,55,66,77,88 in order; busy falls after the 8th byte; pix_idx=0.
REQ-036 cam_we_i=1 held throughout -> cam_we_o=1 before frame_done; 0 from the cycle after the frame_done cycle through the last byte; 1 again after.
REQ-037 FRAME_DUMP_HEADER_EN defined -> tx stream A5,5A,A5,5A,11,...,88 (12 bytes total).
REQ-038 tx_ready held 0 for 50 cycles in SEND -> no tx_start issued; exactly one tx_start once tx_ready=1.
REQ-039 reset pulsed during byte 3 -> next cycle busy=0, tx_start=0, freeze released; a new trigger restarts from byte 11.
REQ-040 second trigger edge and a stray frame_done during a dump -> exactly 8 bytes total; no second dump.
